// File: rtl/vga_pkg.sv
// Shared timing defaults (800x600 @ 60 Hz, 40 MHz pixel clock), counter width,
// receiver FSM states and a counter saturation helper for vga_sync_rx.
package vga_pkg;

    // Default 800x600 timing.
    localparam int H_SYNC_DEF  = 128;
    localparam int H_BACK_DEF  = 88;
    localparam int H_VALID_DEF = 800;
    localparam int H_TOTAL_DEF = 1056;
    localparam int V_SYNC_DEF  = 4;
    localparam int V_BACK_DEF  = 23;
    localparam int V_VALID_DEF = 600;
    localparam int V_TOTAL_DEF = 628;

    // Position counters and measurements are 11 bits and saturate at all-ones.
    localparam int                CNT_W   = 11;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    // Increment that sticks at CNT_MAX instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Clamp a one-bit-wider value back into counter range.
    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W:0] v);
        return v[CNT_W] ? CNT_MAX : v[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/vga_crc16.sv
// CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, no reflection), one byte
// per enabled cycle. 'first' restarts the running value from the init seed so the
// current byte is the first byte of a new message. crc_next is the value after
// folding in the current byte; the running register advances only when enabled.
module vga_crc16
    import vga_pkg::*;
(
    input  logic        vga_clk,
    input  logic        sys_rstn,
    input  logic        en,
    input  logic        first,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    logic [15:0] crc_q;
    logic [15:0] seed;

    assign seed = first ? 16'hFFFF : crc_q;

    // Byte-wide CRC step: xor byte into the top, then eight shift/reduce steps.
    always_comb begin
        crc_next = seed ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[15] ? ({crc_next[14:0], 1'b0} ^ 16'h1021)
                                    : {crc_next[14:0], 1'b0};
        end
    end

    // Running CRC register, advanced once per enabled byte.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            crc_q <= 16'hFFFF;
        end else if (en) begin
            crc_q <= crc_next;
        end
    end

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers pixel position from hsync/vsync, measures line and
// frame periods, locks onto a stream matching the configured timing and reports
// timing faults. Define VGA_SYNC_RX_CRC_EN to add a per-frame CRC-16 of the active
// pixels (frame_crc / crc_valid ports).
//
// Handshake: there is no back-pressure. rx_de qualifies rx_x/rx_y/rx_rgb on the
// cycle it is high; frame_start, timing_err and crc_valid are single-cycle strobes.
module vga_sync_rx
    import vga_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DEF,
    parameter int H_BACK  = H_BACK_DEF,
    parameter int H_VALID = H_VALID_DEF,
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_SYNC  = V_SYNC_DEF,
    parameter int V_BACK  = V_BACK_DEF,
    parameter int V_VALID = V_VALID_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF
) (
    input  logic             vga_clk,
    input  logic             sys_rstn,
    input  logic             hsync,
    input  logic             vsync,
    input  logic [2:0]       vga_rgb,
    output logic [CNT_W-1:0] rx_x,
    output logic [CNT_W-1:0] rx_y,
    output logic [2:0]       rx_rgb,
    output logic             rx_de,
    output logic             frame_start,
    output logic             locked,
    output logic             timing_err,
    output logic [CNT_W-1:0] h_total_meas,
    output logic [CNT_W-1:0] v_total_meas,
`ifdef VGA_SYNC_RX_CRC_EN
    output logic [15:0]      frame_crc,
    output logic             crc_valid,
`endif
    output logic [1:0]       dbg_state
);

    localparam logic [CNT_W:0]   H_TOTAL_P = (CNT_W+1)'(H_TOTAL);
    localparam logic [CNT_W:0]   V_TOTAL_P = (CNT_W+1)'(V_TOTAL);
    localparam logic [CNT_W-1:0] V_LIMIT   = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_ACT_LO  = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_ACT_HI  = CNT_W'(H_SYNC + H_BACK + H_VALID);
    localparam logic [CNT_W-1:0] V_ACT_LO  = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_ACT_HI  = CNT_W'(V_SYNC + V_BACK + V_VALID);

    rx_state_t        state, state_nxt;
    logic             meas_bad, meas_bad_nxt;
    logic             hs_r, hs_d, vs_r, vs_d;
    logic [2:0]       rgb_r, rgb_d;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             vs_pend;

    logic             hs_rise, vs_rise, v_line_rst;
    logic [CNT_W:0]   h_period, v_period;
    logic             line_bad, frame_ok;
    logic             h_act, v_act;

    assign hs_rise    = hs_r & ~hs_d;
    assign vs_rise    = vs_r & ~vs_d;
    // A vsync rise takes effect on the hsync rise that coincides with or follows it.
    assign v_line_rst = hs_rise & (vs_rise | vs_pend);
    assign h_period   = {1'b0, h_cnt} + 1'b1;
    assign v_period   = {1'b0, v_cnt} + 1'b1;
    assign line_bad   = hs_rise && (h_period != H_TOTAL_P);
    assign frame_ok   = (v_period == V_TOTAL_P);

    // Input registers plus one more stage for edge detection and pixel alignment.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            hs_r  <= 1'b0;
            hs_d  <= 1'b0;
            vs_r  <= 1'b0;
            vs_d  <= 1'b0;
            rgb_r <= 3'b000;
            rgb_d <= 3'b000;
        end else begin
            hs_r  <= hsync;
            hs_d  <= hs_r;
            vs_r  <= vsync;
            vs_d  <= vs_r;
            rgb_r <= vga_rgb;
            rgb_d <= rgb_r;
        end
    end

    // Position counters, pending-vsync flag and period measurements.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            vs_pend      <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
        end else begin
            h_cnt <= hs_rise ? '0 : sat_inc(h_cnt);
            if (v_line_rst) begin
                v_cnt <= '0;
            end else if (hs_rise) begin
                v_cnt <= sat_inc(v_cnt);
            end
            if (v_line_rst) begin
                vs_pend <= 1'b0;
            end else if (vs_rise) begin
                vs_pend <= 1'b1;
            end
            if (hs_rise) begin
                h_total_meas <= clamp_cnt(h_period);
            end
            if (v_line_rst) begin
                v_total_meas <= clamp_cnt(v_period);
            end
        end
    end

    // FSM state and measure-window line-fault flag.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state    <= SEARCH;
            meas_bad <= 1'b0;
        end else begin
            state    <= state_nxt;
            meas_bad <= meas_bad_nxt;
        end
    end

    // Next state and strobes; a fault always wins over a coincident frame edge.
    always_comb begin
        state_nxt    = state;
        meas_bad_nxt = meas_bad;
        timing_err   = 1'b0;
        frame_start  = 1'b0;
        unique case (state)
            SEARCH: begin
                if (vs_rise) begin
                    state_nxt    = MEASURE;
                    meas_bad_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (line_bad) begin
                    meas_bad_nxt = 1'b1;
                end
                if (vs_rise) begin
                    meas_bad_nxt = 1'b0;
                    if (meas_bad || line_bad || !frame_ok) begin
                        timing_err = 1'b1;
                        state_nxt  = MEASURE;
                    end else begin
                        state_nxt  = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || (v_cnt >= V_LIMIT) || (vs_rise && !frame_ok)) begin
                    timing_err = 1'b1;
                    state_nxt  = SEARCH;
                end else if (vs_rise) begin
                    frame_start = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    // Active-window decode and aligned pixel outputs.
    always_comb begin
        h_act  = (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI);
        v_act  = (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
        rx_de  = (state == LOCKED) && h_act && v_act;
        rx_x   = rx_de ? (h_cnt - H_ACT_LO) : '0;
        rx_y   = rx_de ? (v_cnt - V_ACT_LO) : '0;
        rx_rgb = rx_de ? rgb_d : 3'b000;
    end

    assign locked    = (state == LOCKED);
    assign dbg_state = state;

`ifdef VGA_SYNC_RX_CRC_EN
    logic        crc_first, crc_last;
    logic [15:0] crc_next;

    assign crc_first = rx_de && (rx_x == '0) && (rx_y == '0);
    assign crc_last  = rx_de && (rx_x == CNT_W'(H_VALID - 1)) && (rx_y == CNT_W'(V_VALID - 1));

    vga_crc16 u_crc (
        .vga_clk  (vga_clk),
        .sys_rstn (sys_rstn),
        .en       (rx_de),
        .first    (crc_first),
        .data     ({5'b00000, rx_rgb}),
        .crc_next (crc_next)
    );

    // Capture the finished frame CRC on the last active pixel; strobe it next cycle.
    always_ff @(posedge vga_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= crc_last;
            if (crc_last) begin
                frame_crc <= crc_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx with a reduced timing set so many frames fit in a short
// run. A frame generator drives sync and random pixels, pushing each pixel the
// receiver should emit into exp_q; a monitor pops and compares on every rx_de.
// Frame-level strobes and lock status are checked against a per-frame table.
module tb_vga_sync_rx;
    import vga_pkg::*;

    localparam int H_SYNC  = 4;
    localparam int H_BACK  = 3;
    localparam int H_VALID = 16;
    localparam int H_TOTAL = 28;
    localparam int V_SYNC  = 2;
    localparam int V_BACK  = 2;
    localparam int V_VALID = 8;
    localparam int V_TOTAL = 14;

    localparam int K_NORMAL  = 0;
    localparam int K_STRETCH = 1;
    localparam int K_NO_VS   = 2;
    localparam int K_RESET   = 3;
    localparam int EVT_LINE  = 6;

    logic        vga_clk;
    logic        sys_rstn;
    logic        hsync, vsync;
    logic [2:0]  vga_rgb;
    logic [10:0] rx_x, rx_y;
    logic [2:0]  rx_rgb;
    logic        rx_de, frame_start, locked, timing_err;
    logic [10:0] h_total_meas, v_total_meas;
    logic [1:0]  dbg_state;
`ifdef VGA_SYNC_RX_CRC_EN
    logic [15:0] frame_crc;
    logic        crc_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int fs_seen  = 0;
    int err_seen = 0;
    int crcv_seen = 0;
    logic [15:0] last_crc = '0;
    logic [24:0] exp_q[$];

    vga_sync_rx #(
        .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_VALID(H_VALID), .H_TOTAL(H_TOTAL),
        .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_VALID(V_VALID), .V_TOTAL(V_TOTAL)
    ) dut (
        .vga_clk      (vga_clk),
        .sys_rstn     (sys_rstn),
        .hsync        (hsync),
        .vsync        (vsync),
        .vga_rgb      (vga_rgb),
        .rx_x         (rx_x),
        .rx_y         (rx_y),
        .rx_rgb       (rx_rgb),
        .rx_de        (rx_de),
        .frame_start  (frame_start),
        .locked       (locked),
        .timing_err   (timing_err),
        .h_total_meas (h_total_meas),
        .v_total_meas (v_total_meas),
`ifdef VGA_SYNC_RX_CRC_EN
        .frame_crc    (frame_crc),
        .crc_valid    (crc_valid),
`endif
        .dbg_state    (dbg_state)
    );

    // Clock
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial CRC-16-CCITT reference, one message byte.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_de"},  32'(rx_de), 0);
        check({tag, "_rx_x"},   32'(rx_x), 0);
        check({tag, "_rx_y"},   32'(rx_y), 0);
        check({tag, "_rx_rgb"}, 32'(rx_rgb), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_err"},    32'(timing_err), 0);
        check({tag, "_fstart"}, 32'(frame_start), 0);
        check({tag, "_hmeas"},  32'(h_total_meas), 0);
        check({tag, "_vmeas"},  32'(v_total_meas), 0);
        check({tag, "_state"},  32'(dbg_state), 32'(SEARCH));
    endtask

    // Drive one frame. kind selects a fault; pixels are expected only if 'out'
    // and the line is below 'cut' (the line where a fault or reset hits).
    task automatic run_frame(input int kind, input bit out, input int cut,
                             input int exp_fs, input int exp_err,
                             input bit exp_lock, input bit chk_meas);
        int          lines, len, fs0, err0, crc0, px, py;
        bit          full;
        logic [2:0]  rgb;
        logic [15:0] mcrc;
        lines = (kind == K_NO_VS) ? 2 * V_TOTAL : V_TOTAL;
        fs0   = fs_seen;
        err0  = err_seen;
        crc0  = crcv_seen;
        mcrc  = 16'hFFFF;
        full  = out && (kind == K_NORMAL);
        for (int l = 0; l < lines; l++) begin
            len = H_TOTAL + ((kind == K_STRETCH && l == EVT_LINE - 1) ? 1 : 0);
            for (int h = 0; h < len; h++) begin
                @(negedge vga_clk);
                px  = h - (H_SYNC + H_BACK);
                py  = l - (V_SYNC + V_BACK);
                rgb = 3'($urandom_range(0, 7));
                if (px == 0 && py == 0) rgb = 3'b111;
                hsync    = (h < H_SYNC);
                vsync    = (kind != K_NO_VS) && (l < V_SYNC);
                vga_rgb  = rgb;
                sys_rstn = !(kind == K_RESET && l == EVT_LINE && h <= 2);
                if (out && l < cut && px >= 0 && px < H_VALID && py >= 0 && py < V_VALID) begin
                    exp_q.push_back({11'(px), 11'(py), rgb});
                    mcrc = crc_byte(mcrc, {5'b00000, rgb});
                end
                if (kind == K_RESET && l == EVT_LINE && h == 2) begin
                    #1;
                    check_all_zero("midreset");
                end
            end
        end
        #1;
        check("locked_at_frame_end", 32'(locked), 32'(exp_lock));
        check("frame_start_pulses", 32'(fs_seen - fs0), 32'(exp_fs));
        check("timing_err_pulses", 32'(err_seen - err0), 32'(exp_err));
        if (chk_meas) begin
            check("h_total_meas", 32'(h_total_meas), 32'(H_TOTAL));
            check("v_total_meas", 32'(v_total_meas), 32'(V_TOTAL));
        end
`ifdef VGA_SYNC_RX_CRC_EN
        check("crc_valid_pulses", 32'(crcv_seen - crc0), full ? 1 : 0);
        if (full) check("frame_crc", 32'(last_crc), 32'(mcrc));
`else
        if (full) check("crc_off_no_pulse", 32'(crcv_seen - crc0), 0);
`endif
    endtask

    // Monitor: strobe counters and scoreboard pops on every active pixel.
    initial begin
        logic [24:0] exp;
        forever begin
            @(negedge vga_clk);
            if (frame_start) fs_seen++;
            if (timing_err) err_seen++;
`ifdef VGA_SYNC_RX_CRC_EN
            if (crc_valid) begin
                crcv_seen++;
                last_crc = frame_crc;
            end
`endif
            if (rx_de) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got x=%0d y=%0d rgb=%0d expected none at %0t",
                             rx_x, rx_y, rx_rgb, $time);
                end else begin
                    exp = exp_q.pop_front();
                    check("pixel_xyrgb", 32'({rx_x, rx_y, rx_rgb}), 32'(exp));
                end
            end else begin
                check("idle_outputs_zero", 32'({rx_x, rx_y, rx_rgb}), 0);
            end
        end
    end

    // Stimulus script
    initial begin
        sys_rstn = 1'b0;
        hsync    = 1'b0;
        vsync    = 1'b0;
        vga_rgb  = 3'b000;
        for (int i = 0; i < 6; i++) begin
            @(negedge vga_clk);
            hsync   = 1'($urandom_range(0, 1));
            vsync   = 1'($urandom_range(0, 1));
            vga_rgb = 3'($urandom_range(0, 7));
        end
        #1;
        check_all_zero("reset");
        @(negedge vga_clk);
        hsync    = 1'b0;
        vsync    = 1'b0;
        sys_rstn = 1'b1;
        repeat (5) @(negedge vga_clk);

        //        kind       out cut       fs err lock meas
        run_frame(K_NORMAL,  0, V_TOTAL,   0, 0,  0,   0);  // search -> measure
        run_frame(K_NORMAL,  1, V_TOTAL,   0, 0,  1,   1);  // locks at its vsync
        run_frame(K_NORMAL,  1, V_TOTAL,   1, 0,  1,   1);
        run_frame(K_STRETCH, 1, EVT_LINE,  1, 1,  0,   0);  // long line drops lock
        run_frame(K_NORMAL,  0, V_TOTAL,   0, 0,  0,   0);
        run_frame(K_NORMAL,  1, V_TOTAL,   0, 0,  1,   1);  // relocked
        run_frame(K_NORMAL,  1, V_TOTAL,   1, 0,  1,   1);
        run_frame(K_NO_VS,   0, V_TOTAL,   0, 1,  0,   0);  // missing vsync
        run_frame(K_NORMAL,  0, V_TOTAL,   0, 0,  0,   0);
        run_frame(K_NORMAL,  1, V_TOTAL,   0, 0,  1,   1);
        run_frame(K_RESET,   1, EVT_LINE,  1, 0,  0,   0);  // reset mid-frame
        run_frame(K_NORMAL,  0, V_TOTAL,   0, 0,  0,   0);
        run_frame(K_NORMAL,  1, V_TOTAL,   0, 0,  1,   1);
        run_frame(K_NORMAL,  1, V_TOTAL,   1, 0,  1,   1);

        repeat (8) @(negedge vga_clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
